// File: rtl/cpu_pkg.sv
// Shared processor-core definitions: branch-unit instruction IDs and the
// program-counter sequencer state encoding.
package cpu_pkg;

  localparam logic [31:0] ID_BEQ  = 32'd15;
  localparam logic [31:0] ID_BNE  = 32'd16;
  localparam logic [31:0] ID_BGT  = 32'd17;
  localparam logic [31:0] ID_BGTE = 32'd18;
  localparam logic [31:0] ID_BLE  = 32'd19;
  localparam logic [31:0] ID_BLEQ = 32'd20;
  localparam logic [31:0] ID_J    = 32'd21;
  localparam logic [31:0] ID_JR   = 32'd22;
  localparam logic [31:0] ID_JAL  = 32'd23;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    UPDATE
  } state_t;

  function automatic logic is_cond_branch(input logic [31:0] id);
    return (id >= ID_BEQ) && (id <= ID_BLEQ);
  endfunction

  function automatic logic is_abs_jump(input logic [31:0] id);
    return (id >= ID_J) && (id <= ID_JAL);
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC resolution.
//   pc      in  PC_W  current PC (word address)
//   id_q    in  32    latched instruction ID
//   br_q    in  32    latched branch-unit result (offset or absolute target)
//   next_pc out PC_W  resolved next PC, arithmetic wraps mod 2^PC_W
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic [31:0]     id_q,
  input  logic [31:0]     br_q,
  output logic [PC_W-1:0] next_pc
);

  localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_trunc;

  assign pc_inc   = pc + ONE;
  assign br_trunc = br_q[PC_W-1:0];

  always_comb begin
    next_pc = pc_inc;
    if (is_cond_branch(id_q)) begin
      // Zero offset means not taken; both cases land on pc+1.
      if (br_q != '0) next_pc = pc_inc + br_trunc;
    end else if (is_abs_jump(id_q)) begin
      next_pc = br_trunc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle program-counter controller: fetch over a req/ack handshake,
// decode, execute, then resolve the next PC and issue the jal link write.
//   clk, rst        clock, asynchronous active-high reset
//   run             permits a new fetch (sampled in IDLE and UPDATE)
//   imem_req/addr   fetch request held until imem_ack; address = pc
//   imem_ack/rdata  fetch completion and instruction word
//   ir, ir_valid    latched instruction, 1-cycle pulse in DECODE
//   instr_id        decoded ID, valid in DECODE
//   exec_done       datapath done; br_out valid with it
//   link_we/addr/data  jal register-file write (pc+1 to LINK_REG)
//   pc              current PC
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     LINK_REG = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir,
  output logic            ir_valid,
  input  logic [31:0]     instr_id,
  input  logic            exec_done,
  input  logic [31:0]     br_out,
  output logic            link_we,
  output logic [4:0]      link_addr,
  output logic [31:0]     link_data,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state;
  logic [31:0]     id_q;
  logic [31:0]     br_q;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc    = pc + ONE;
  assign imem_addr = pc;
  assign link_addr = 5'(LINK_REG);

  pc_next_calc #(
    .PC_W(PC_W)
  ) u_next (
    .pc     (pc),
    .id_q   (id_q),
    .br_q   (br_q),
    .next_pc(next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      id_q      <= '0;
      br_q      <= '0;
      imem_req  <= 1'b0;
      ir_valid  <= 1'b0;
      link_we   <= 1'b0;
      link_data <= '0;
    end else begin
      ir_valid <= 1'b0;
      link_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            ir_valid <= 1'b1;
            state    <= DECODE;
          end
        end
        DECODE: begin
          id_q  <= instr_id;
          state <= EXEC;
        end
        EXEC: begin
          if (exec_done) begin
            br_q  <= br_out;
            state <= UPDATE;
            // Link write is registered one edge early so it is visible
            // during UPDATE, while pc still holds the jal address.
            if (id_q == ID_JAL) begin
              link_we   <= 1'b1;
              link_data <= 32'(pc_inc);
            end
          end
        end
        UPDATE: begin
          pc <= next_pc;
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
